// File: rtl/eth_phy_10g_link_ctrl_if.sv
// Control/status bundle between the 10G PHY link controller and the PCS/SERDES side.
// link_down_count is present only when ETH_LINK_CTRL_STATS_EN is defined.
interface eth_phy_10g_link_ctrl_if;
    logic       cfg_enable;
    logic       rx_block_lock;
    logic       rx_high_ber;
    logic       serdes_rx_reset_req;
    logic       rx_status;
    logic [1:0] link_state;
    logic [7:0] reset_count;
`ifdef ETH_LINK_CTRL_STATS_EN
    logic [7:0] link_down_count;
`endif

    modport master (
        output cfg_enable,
        output rx_block_lock,
        output rx_high_ber,
        input  serdes_rx_reset_req,
        input  rx_status,
        input  link_state,
        input  reset_count
`ifdef ETH_LINK_CTRL_STATS_EN
        , input link_down_count
`endif
    );

    modport slave (
        input  cfg_enable,
        input  rx_block_lock,
        input  rx_high_ber,
        output serdes_rx_reset_req,
        output rx_status,
        output link_state,
        output reset_count
`ifdef ETH_LINK_CTRL_STATS_EN
        , output link_down_count
`endif
    );
endinterface

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10GBASE-R receive link controller: waits for block lock, resets the SERDES on timeout,
// debounces lock/BER into link up. ETH_LINK_CTRL_STATS_EN adds the link-down statistic.
module eth_phy_10g_link_ctrl #(
    parameter int LOCK_TIMEOUT = 1024,
    parameter int RESET_CYCLES = 8,
    parameter int UP_DEBOUNCE  = 125
) (
    input logic                    rx_clk,
    input logic                    rx_rst_n,
    eth_phy_10g_link_ctrl_if.slave link
);
    localparam int TW = $clog2(LOCK_TIMEOUT);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DW = (UP_DEBOUNCE > 1) ? $clog2(UP_DEBOUNCE) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [RW-1:0] RST_ONE    = RW'(1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(UP_DEBOUNCE - 1);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RESET     = 2'd1,
        ST_DEBOUNCE  = 2'd2,
        ST_UP        = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [RW-1:0] rst_cnt_r;
    logic [DW-1:0] deb_cnt_r;
    logic          req_r;
    logic          status_r;
    logic [7:0]    reset_count_r;
`ifdef ETH_LINK_CTRL_STATS_EN
    logic [7:0]    link_down_count_r;
`endif

    // Link FSM with its timers, registered outputs and saturating statistics.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_r           <= ST_WAIT_LOCK;
            timer_r           <= '0;
            rst_cnt_r         <= '0;
            deb_cnt_r         <= '0;
            req_r             <= 1'b0;
            status_r          <= 1'b0;
            reset_count_r     <= 8'd0;
`ifdef ETH_LINK_CTRL_STATS_EN
            link_down_count_r <= 8'd0;
`endif
        end else if (!link.cfg_enable) begin
            state_r   <= ST_WAIT_LOCK;
            timer_r   <= '0;
            rst_cnt_r <= '0;
            deb_cnt_r <= '0;
            req_r     <= 1'b0;
            status_r  <= 1'b0;
        end else begin
            req_r    <= 1'b0;
            status_r <= 1'b0;
            case (state_r)
                ST_WAIT_LOCK: begin
                    rst_cnt_r <= '0;
                    deb_cnt_r <= '0;
                    // Lock outranks a coinciding timeout.
                    if (link.rx_block_lock) begin
                        state_r <= ST_DEBOUNCE;
                        timer_r <= '0;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r       <= ST_RESET;
                        timer_r       <= '0;
                        req_r         <= 1'b1;
                        reset_count_r <= sat_inc8(reset_count_r);
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_r == RST_LAST) begin
                        state_r   <= ST_WAIT_LOCK;
                        rst_cnt_r <= '0;
                        timer_r   <= '0;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RST_ONE;
                        req_r     <= 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!link.rx_block_lock) begin
                        state_r   <= ST_WAIT_LOCK;
                        timer_r   <= '0;
                        deb_cnt_r <= '0;
                    end else if (!link.rx_high_ber && (deb_cnt_r == DEB_LAST)) begin
                        state_r   <= ST_UP;
                        timer_r   <= '0;
                        deb_cnt_r <= '0;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r       <= ST_RESET;
                        timer_r       <= '0;
                        deb_cnt_r     <= '0;
                        req_r         <= 1'b1;
                        reset_count_r <= sat_inc8(reset_count_r);
                    end else begin
                        timer_r   <= timer_r + TIMER_ONE;
                        deb_cnt_r <= link.rx_high_ber ? '0 : deb_cnt_r + DEB_ONE;
                    end
                end
                ST_UP: begin
                    // rx_status follows "still up after this edge", so it rises one edge after entry.
                    if (!link.rx_block_lock || link.rx_high_ber) begin
                        state_r <= ST_WAIT_LOCK;
                        timer_r <= '0;
`ifdef ETH_LINK_CTRL_STATS_EN
                        link_down_count_r <= sat_inc8(link_down_count_r);
`endif
                    end else begin
                        status_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_WAIT_LOCK;
                    timer_r   <= '0;
                    rst_cnt_r <= '0;
                    deb_cnt_r <= '0;
                end
            endcase
        end
    end

    assign link.serdes_rx_reset_req = req_r;
    assign link.rx_status           = status_r;
    assign link.link_state          = state_r;
    assign link.reset_count         = reset_count_r;
`ifdef ETH_LINK_CTRL_STATS_EN
    assign link.link_down_count     = link_down_count_r;
`endif

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Scoreboard bench for eth_phy_10g_link_ctrl with LOCK_TIMEOUT=16, RESET_CYCLES=4, UP_DEBOUNCE=4.
// Link-down statistic checks are compiled only with ETH_LINK_CTRL_STATS_EN.
module tb_eth_phy_10g_link_ctrl;
    typedef struct packed {
        logic       req;
        logic       up;
        logic [1:0] state;
        logic [7:0] rcnt;
    } obs_t;

    logic rx_clk;
    logic rx_rst_n;
    int   checks;
    int   errors;
    obs_t sb[$];
    obs_t got;
    obs_t ex;

    eth_phy_10g_link_ctrl_if link_if ();

    eth_phy_10g_link_ctrl #(
        .LOCK_TIMEOUT(16),
        .RESET_CYCLES(4),
        .UP_DEBOUNCE (4)
    ) dut (
        .rx_clk  (rx_clk),
        .rx_rst_n(rx_rst_n),
        .link    (link_if)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    function automatic obs_t observe();
        obs_t o;
        o.req   = link_if.serdes_rx_reset_req;
        o.up    = link_if.rx_status;
        o.state = link_if.link_state;
        o.rcnt  = link_if.reset_count;
        return o;
    endfunction

    function automatic obs_t mk(input logic req, input logic up, input int state, input int rcnt);
        obs_t o;
        o.req   = req;
        o.up    = up;
        o.state = 2'(state);
        o.rcnt  = 8'(rcnt);
        return o;
    endfunction

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic drive(input logic lock, input logic ber, input logic en);
        link_if.rx_block_lock = lock;
        link_if.rx_high_ber   = ber;
        link_if.cfg_enable    = en;
    endtask

    // Next rising edge after this task returns is edge 1.
    task automatic apply_reset();
        rx_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rx_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rx_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        sb.push_back(mk(1'b0, 1'b0, 0, 0));
        got = observe();
        ex  = sb.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, ex);
        end
`ifdef ETH_LINK_CTRL_STATS_EN
        checks++;
        if (link_if.link_down_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_ldc: got %0d expected 0", link_if.link_down_count);
        end
`endif
    endtask

    task automatic test_link_up();
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            drive(e >= 3, 1'b0, 1'b1);
            sb.push_back(mk(1'b0, e >= 8, (e <= 2) ? 0 : ((e <= 6) ? 2 : 3), 0));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL link_up edge %0d: got %h expected %h", e, got, ex);
            end
        end
    endtask

    // Continues from the UP state left by test_link_up.
    task automatic test_link_drop();
        for (int e = 1; e <= 8; e++) begin
            drive(e != 1, 1'b0, 1'b1);
            if (e == 1)
                sb.push_back(mk(1'b0, 1'b0, 0, 0));
            else if (e <= 5)
                sb.push_back(mk(1'b0, 1'b0, 2, 0));
            else
                sb.push_back(mk(1'b0, e >= 7, 3, 0));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL link_drop edge %0d: got %h expected %h", e, got, ex);
            end
        end
`ifdef ETH_LINK_CTRL_STATS_EN
        checks++;
        if (link_if.link_down_count !== 8'd1) begin
            errors++;
            $display("FAIL link_drop_ldc: got %0d expected 1", link_if.link_down_count);
        end
`endif
    endtask

    task automatic test_debounce();
        apply_reset();
        for (int e = 1; e <= 10; e++) begin
            drive(1'b1, e == 4, 1'b1);
            sb.push_back(mk(1'b0, e >= 9, (e <= 7) ? 2 : 3, 0));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL debounce_ber edge %0d: got %h expected %h", e, got, ex);
            end
        end
        apply_reset();
        for (int e = 1; e <= 6; e++) begin
            drive(e <= 3, 1'b0, 1'b1);
            sb.push_back(mk(1'b0, 1'b0, (e <= 3) ? 2 : 0, 0));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL debounce_lock_loss edge %0d: got %h expected %h", e, got, ex);
            end
        end
    endtask

    task automatic test_timeout_reset();
        apply_reset();
        for (int e = 1; e <= 6020; e++) begin
            int   p;
            logic inr;
            drive(1'b0, 1'b0, 1'b1);
            p   = (e >= 16) ? ((e - 16) / 20 + 1) : 0;
            inr = (e >= 16) && (((e - 16) % 20) < 4);
            sb.push_back(mk(inr, 1'b0, inr ? 1 : 0, (p > 255) ? 255 : p));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL timeout_reset edge %0d: got %h expected %h", e, got, ex);
            end
        end
    endtask

    task automatic test_lock_at_timeout();
        apply_reset();
        for (int e = 1; e <= 21; e++) begin
            drive(e >= 16, 1'b0, 1'b1);
            sb.push_back(mk(1'b0, e >= 21, (e <= 15) ? 0 : ((e <= 19) ? 2 : 3), 0));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL lock_at_timeout edge %0d: got %h expected %h", e, got, ex);
            end
        end
    endtask

    task automatic test_cfg_disable();
        apply_reset();
        for (int e = 1; e <= 40; e++) begin
            drive(1'b0, 1'b0, !((e >= 18) && (e <= 20)));
            if (e <= 15)
                sb.push_back(mk(1'b0, 1'b0, 0, 0));
            else if (e <= 17)
                sb.push_back(mk(1'b1, 1'b0, 1, 1));
            else if (e <= 35)
                sb.push_back(mk(1'b0, 1'b0, 0, 1));
            else if (e <= 39)
                sb.push_back(mk(1'b1, 1'b0, 1, 2));
            else
                sb.push_back(mk(1'b0, 1'b0, 0, 2));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL cfg_disable edge %0d: got %h expected %h", e, got, ex);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int e = 1; e <= 15; e++) begin
            drive(e != 9, 1'b0, 1'b1);
            if (e <= 4)
                sb.push_back(mk(1'b0, 1'b0, 2, 0));
            else if (e <= 8)
                sb.push_back(mk(1'b0, e >= 6, 3, 0));
            else if (e == 9)
                sb.push_back(mk(1'b0, 1'b0, 0, 0));
            else if (e <= 13)
                sb.push_back(mk(1'b0, 1'b0, 2, 0));
            else
                sb.push_back(mk(1'b0, e >= 15, 3, 0));
            tick();
            got = observe();
            ex  = sb.pop_front();
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL back_to_back_up edge %0d: got %h expected %h", e, got, ex);
            end
        end
`ifdef ETH_LINK_CTRL_STATS_EN
        checks++;
        if (link_if.link_down_count !== 8'd1) begin
            errors++;
            $display("FAIL back_to_back_ldc: got %0d expected 1", link_if.link_down_count);
        end
`endif
        // Mid-UP: assert reset between edges and look before any clock edge.
        rx_rst_n = 1'b0;
        sb.push_back(mk(1'b0, 1'b0, 0, 0));
        #1;
        got = observe();
        ex  = sb.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL async_reset_up: got %h expected %h", got, ex);
        end
`ifdef ETH_LINK_CTRL_STATS_EN
        checks++;
        if (link_if.link_down_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_ldc: got %0d expected 0", link_if.link_down_count);
        end
`endif
        apply_reset();
        for (int e = 1; e <= 17; e++) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
        end
        sb.push_back(mk(1'b1, 1'b0, 1, 1));
        got = observe();
        ex  = sb.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL in_reset_state: got %h expected %h", got, ex);
        end
        rx_rst_n = 1'b0;
        sb.push_back(mk(1'b0, 1'b0, 0, 0));
        #1;
        got = observe();
        ex  = sb.pop_front();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL async_reset_in_reset: got %h expected %h", got, ex);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rx_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        test_reset();
        test_link_up();
        test_link_drop();
        test_debounce();
        test_timeout_reset();
        test_lock_at_timeout();
        test_cfg_disable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
